// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, taken-branch flush and ecall halt for a
// pipeline whose state registers update on the falling clock edge.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs1_index,
  input  logic [4:0]       d_rs2_index,
  input  logic             d_uses_rs1,
  input  logic             d_uses_rs2,
  input  logic [4:0]       e_rd_index,
  input  logic             e_wb_en,
  input  logic             e_wb_sel,
  input  logic             e_jb_taken,
  input  logic             e_ecall_sig,
  output logic             stall,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             load_use_s;
  logic             run_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  // A bubble in D/E has wb_en=0, so it can never look like a pending load.
  assign load_use_s = e_wb_en & e_wb_sel & (e_rd_index != 5'd0) &
                      ((d_uses_rs1 & (d_rs1_index == e_rd_index)) |
                       (d_uses_rs2 & (d_rs2_index == e_rd_index)));
  assign run_s = (state_q == RUN);

  // Pipeline control strobes; a taken branch squashes the load-use stall.
  always_comb begin
    stall    = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    if (!rst) begin
      stall    = 1'b0;
      fd_flush = 1'b0;
      de_flush = 1'b0;
    end else if (!run_s) begin
      stall    = 1'b1;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (e_jb_taken) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (load_use_s) begin
      stall    = 1'b1;
      de_flush = 1'b1;
    end else begin
      stall    = 1'b0;
    end
  end

  // Next-state and counter updates; everything freezes once halted.
  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    case (state_q)
      RUN: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q, 1'b1);
        flush_cnt_d = sat_inc(flush_cnt_q, e_jb_taken);
        stall_cnt_d = sat_inc(stall_cnt_q, load_use_s & ~e_jb_taken);
        if (e_ecall_sig) begin
          state_d = HALT;
          halt_d  = 1'b1;
        end else begin
          state_d = RUN;
          halt_d  = 1'b0;
        end
      end
      HALT: begin
        state_d = HALT;
        halt_d  = 1'b1;
      end
      default: begin
        state_d = RUN;
        halt_d  = 1'b0;
      end
    endcase
  end

  // State registers share the falling edge with the pipeline registers.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
      cycle_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner cases and
// randomized traffic against a behavioural model; a 4-bit twin checks saturation.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  d_rs1_index, d_rs2_index, e_rd_index;
  logic        d_uses_rs1, d_uses_rs2, e_wb_en, e_wb_sel, e_jb_taken, e_ecall_sig;
  logic        stall, fd_flush, de_flush, halt;
  logic [31:0] stall_cnt, flush_cnt, cycle_cnt;
  logic        stall4, fd_flush4, de_flush4, halt4;
  logic [3:0]  stall_cnt4, flush_cnt4, cycle_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  bit     m_halt;
  longint m_stall, m_flush, m_cyc;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wb_en, wb_sel, jb, ecall;
    logic       exp_stall, exp_fd, exp_de;
  } vec_t;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .d_rs1_index(d_rs1_index), .d_rs2_index(d_rs2_index),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_rd_index(e_rd_index), .e_wb_en(e_wb_en), .e_wb_sel(e_wb_sel),
    .e_jb_taken(e_jb_taken), .e_ecall_sig(e_ecall_sig),
    .stall(stall), .fd_flush(fd_flush), .de_flush(de_flush), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .cycle_cnt(cycle_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .d_rs1_index(d_rs1_index), .d_rs2_index(d_rs2_index),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_rd_index(e_rd_index), .e_wb_en(e_wb_en), .e_wb_sel(e_wb_sel),
    .e_jb_taken(e_jb_taken), .e_ecall_sig(e_ecall_sig),
    .stall(stall4), .fd_flush(fd_flush4), .de_flush(de_flush4), .halt(halt4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .cycle_cnt(cycle_cnt4)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [4:0] rd, input logic wb_en,
                              input logic wb_sel, input logic jb,
                              input logic es, input logic ef, input logic ed);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.wb_en = wb_en; v.wb_sel = wb_sel; v.jb = jb; v.ecall = 1'b0;
    v.exp_stall = es; v.exp_fd = ef; v.exp_de = ed;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    d_rs1_index = v.rs1; d_uses_rs1 = v.u1;
    d_rs2_index = v.rs2; d_uses_rs2 = v.u2;
    e_rd_index = v.rd; e_wb_en = v.wb_en; e_wb_sel = v.wb_sel;
    e_jb_taken = v.jb; e_ecall_sig = v.ecall;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_halt"}, halt, m_halt);
    chk({tag, "_stall_cnt"}, stall_cnt, m_stall);
    chk({tag, "_flush_cnt"}, flush_cnt, m_flush);
    chk({tag, "_cycle_cnt"}, cycle_cnt, m_cyc);
    chk({tag, "_cycle_cnt4"}, cycle_cnt4, sat15(m_cyc));
    chk({tag, "_stall_cnt4"}, stall_cnt4, sat15(m_stall));
    chk({tag, "_flush_cnt4"}, flush_cnt4, sat15(m_flush));
  endtask

  // One pipeline cycle: drive after the rising edge, check strobes, then the falling edge.
  task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
    bit lu, es, ef, ed;
    @(posedge clk); #1;
    apply(v);
    #1;
    lu = v.wb_en && v.wb_sel && (v.rd != 5'd0) &&
         ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (m_halt)    begin es = 1; ef = 1; ed = 1; end
    else if (v.jb) begin es = 0; ef = 1; ed = 1; end
    else if (lu)   begin es = 1; ef = 0; ed = 1; end
    else           begin es = 0; ef = 0; ed = 0; end
    chk({tag, "_stall"}, stall, es);
    chk({tag, "_fd_flush"}, fd_flush, ef);
    chk({tag, "_de_flush"}, de_flush, ed);
    if (use_tbl) begin
      chk({tag, "_tbl_stall"}, stall, v.exp_stall);
      chk({tag, "_tbl_fd_flush"}, fd_flush, v.exp_fd);
      chk({tag, "_tbl_de_flush"}, de_flush, v.exp_de);
    end
    @(negedge clk); #1;
    if (!m_halt) begin
      m_cyc++;
      if (v.jb) m_flush++;
      else if (lu) m_stall++;
      if (v.ecall) m_halt = 1;
    end
    chk_regs(tag);
  endtask

  // Reset pulse between edges; after release one idle RUN cycle elapses.
  task automatic do_reset(input string tag);
    vec_t idle;
    idle = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    m_halt = 0; m_stall = 0; m_flush = 0; m_cyc = 0;
    chk({tag, "_rst_stall"}, stall, 0);
    chk({tag, "_rst_fd_flush"}, fd_flush, 0);
    chk({tag, "_rst_de_flush"}, de_flush, 0);
    chk_regs({tag, "_rst"});
    apply(idle);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #1;
    m_cyc = 1;
    chk_regs({tag, "_post"});
  endtask

  vec_t tbl[8];
  vec_t v;
  int   halt_age;

  initial begin
    rst = 1'b0;
    apply(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    m_halt = 0; m_stall = 0; m_flush = 0; m_cyc = 0;
    #3;
    chk("reset_halt", halt, 0);
    chk("reset_stall", stall, 0);
    chk("reset_cycle_cnt", cycle_cnt, 0);
    do_reset("init");

    //         rs1    u1    rs2    u2    rd     wb_en wb_sel jb    stall fd    de
    tbl[0] = mk(5'd1, 1'b1, 5'd5,  1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[1] = mk(5'd1, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(5'd1, 1'b1, 5'd5,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mk(5'd1, 1'b1, 5'd5,  1'b1, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[4] = mk(5'd0, 1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5] = mk(5'd9, 1'b1, 5'd3,  1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[6] = mk(5'd9, 1'b0, 5'd3,  1'b1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(5'd2, 1'b0, 5'd7,  1'b0, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Reset while a load-use stall is being asserted.
    run_cycle(tbl[0], 1'b1, "midstall");
    do_reset("midstall");
    chk("midstall_stall_cnt", stall_cnt, 0);

    // Saturation: 20 RUN cycles since reset.
    do_reset("sat");
    for (int i = 0; i < 19; i++) run_cycle(tbl[4], 1'b0, "sat");
    chk("sat_cycle_cnt4", cycle_cnt4, 15);
    chk("sat_cycle_cnt32", cycle_cnt, 20);

    // Ecall on the fourth RUN cycle, then branches while halted.
    do_reset("ecall");
    run_cycle(tbl[4], 1'b0, "ecall_pre");
    run_cycle(tbl[7], 1'b0, "ecall_pre");
    v = tbl[4]; v.ecall = 1'b1;
    run_cycle(v, 1'b0, "ecall");
    chk("ecall_halt", halt, 1);
    chk("ecall_cycle_cnt", cycle_cnt, 4);
    chk("ecall_flush_cnt", flush_cnt, 1);
    for (int i = 0; i < 3; i++) run_cycle(tbl[7], 1'b0, "halted");
    chk("halted_flush_cnt", flush_cnt, 1);
    chk("halted_cycle_cnt", cycle_cnt, 4);
    chk("halted_stall", stall, 1);
    do_reset("halt_rst");
    chk("halt_rst_halt", halt, 0);
    run_cycle(tbl[0], 1'b1, "after_rst");

    // Randomized traffic with occasional ecall and recovery by reset.
    halt_age = 0;
    for (int i = 0; i < 600; i++) begin
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom); v.u2 = 1'($urandom);
      v.wb_en = 1'($urandom); v.wb_sel = 1'($urandom);
      v.jb = ($urandom_range(0, 3) == 0);
      v.ecall = ($urandom_range(0, 39) == 0);
      v.exp_stall = 1'b0; v.exp_fd = 1'b0; v.exp_de = 1'b0;
      run_cycle(v, 1'b0, "rnd");
      if (m_halt) halt_age++;
      if (halt_age > 4) begin
        do_reset("rnd");
        halt_age = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
